// File: rtl/regfile_sb.sv
// regfile_sb: register file with per-register tag scoreboard; define REGFILE_BYPASS_EN for same-cycle writeback forwarding
module regfile_sb #(
    parameter int READER     = 2,
    parameter int WRITER     = 2,
    parameter int RESERVER   = 1,
    parameter int COUNT      = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4,
    parameter int AW         = $clog2(COUNT)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [AW-1:0]                rd_addr   [READER],
    output logic [DATA_WIDTH-1:0]        rd_data   [READER],
    output logic                         rd_ready  [READER],
    output logic [TAG_WIDTH-1:0]         rd_tag    [READER],
    input  logic                         rsv_valid [RESERVER],
    input  logic [AW-1:0]                rsv_addr  [RESERVER],
    input  logic [TAG_WIDTH-1:0]         rsv_tag   [RESERVER],
    input  logic                         wb_valid  [WRITER],
    input  logic [AW-1:0]                wb_addr   [WRITER],
    input  logic [TAG_WIDTH-1:0]         wb_tag    [WRITER],
    input  logic [DATA_WIDTH-1:0]        wb_data   [WRITER],
    input  logic                         flush,
    output logic [$clog2(COUNT+1)-1:0]   busy_count
);
    localparam int CW = $clog2(COUNT+1);

    logic [DATA_WIDTH-1:0] data_q [COUNT];
    logic [DATA_WIDTH-1:0] data_d [COUNT];
    logic [TAG_WIDTH-1:0]  tag_q  [COUNT];
    logic [TAG_WIDTH-1:0]  tag_d  [COUNT];
    logic [COUNT-1:0]      pend_q;
    logic [COUNT-1:0]      pend_d;
    logic [WRITER-1:0]     wb_acc;
    logic [CW-1:0]         busy_d;

    // A writeback lands only on a free register or on the tag that currently owns it
    for (genvar i = 0; i < WRITER; i++) begin : g_acc
        assign wb_acc[i] = wb_valid[i] && wb_addr[i] != '0 &&
                           (!pend_q[wb_addr[i]] || wb_tag[i] == tag_q[wb_addr[i]]);
    end

    // Next state: ports applied highest-first so the lowest index overwrites; reserves after writebacks so they own the scoreboard
    always_comb begin
        data_d = data_q;
        pend_d = pend_q;
        tag_d  = tag_q;
        busy_d = '0;
        for (int w = WRITER - 1; w >= 0; w--) begin
            if (wb_acc[w]) begin
                data_d[wb_addr[w]] = wb_data[w];
                pend_d[wb_addr[w]] = 1'b0;
            end
        end
        for (int s = RESERVER - 1; s >= 0; s--) begin
            if (rsv_valid[s] && rsv_addr[s] != '0 && !flush) begin
                pend_d[rsv_addr[s]] = 1'b1;
                tag_d[rsv_addr[s]]  = rsv_tag[s];
            end
        end
        if (flush) begin
            pend_d = '0;
            tag_d  = '{default: '0};
        end
        for (int r = 0; r < COUNT; r++) busy_d = busy_d + CW'(pend_d[r]);
    end

    // State registers, cleared asynchronously as a whole
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q     <= '{default: '0};
            tag_q      <= '{default: '0};
            pend_q     <= '0;
            busy_count <= '0;
        end else begin
            data_q     <= data_d;
            tag_q      <= tag_d;
            pend_q     <= pend_d;
            busy_count <= busy_d;
        end
    end

    // Operand read; register 0 is never written or reserved so it naturally reads 0/ready
    always_comb begin
        for (int i = 0; i < READER; i++) begin
            rd_data[i]  = data_q[rd_addr[i]];
            rd_ready[i] = !pend_q[rd_addr[i]];
            rd_tag[i]   = pend_q[rd_addr[i]] ? tag_q[rd_addr[i]] : '0;
`ifdef REGFILE_BYPASS_EN
            for (int w = WRITER - 1; w >= 0; w--) begin
                if (wb_acc[w] && wb_addr[w] == rd_addr[i]) begin
                    rd_data[i]  = wb_data[w];
                    rd_ready[i] = 1'b1;
                    rd_tag[i]   = '0;
                end
            end
`endif
        end
    end
endmodule
